// File: rtl/ad_pkg.sv
// Shared types for the ad front-end line packer: FSM states and the packed output word.
package ad_pkg;

    localparam int unsigned AD_DW = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_LINE,
        ST_SKIP,
        ST_CAPTURE
    } state_t;

    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [AD_DW-1:0] ch1;
        logic [AD_DW-1:0] ch2;
    } ad_word_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO with a registered output stage; capacity counts the output register.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    mem_cnt;
    logic             out_valid;
    logic             pop;
    logic             load;
    logic             accept;
    logic             from_mem;
    logic             bypass;
    logic             to_mem;

    assign full  = (32'(mem_cnt) + 32'(out_valid)) == DEPTH;
    assign empty = !out_valid;

    // A pop frees the output slot in the same cycle, so a full FIFO can still accept.
    always_comb begin
        pop      = out_valid && rd_en;
        load     = !out_valid || pop;
        accept   = wr_en && (!full || pop);
        from_mem = load && (mem_cnt != '0);
        bypass   = load && (mem_cnt == '0) && accept;
        to_mem   = accept && !bypass;
    end

    always_ff @(posedge clk) begin
        if (to_mem) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else begin
            if (to_mem) wr_ptr <= wr_ptr + AW'(1);
            if (from_mem) begin
                dout      <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + AW'(1);
                out_valid <= 1'b1;
            end else if (bypass) begin
                dout      <= din;
                out_valid <= 1'b1;
            end else if (load) begin
                out_valid <= 1'b0;
            end
            mem_cnt <= mem_cnt + CW'(to_mem) - CW'(from_mem);
        end
    end

endmodule

// File: rtl/ad_line_packer.sv
// Crops each sync-delimited line to an active window, packs both ADC channels
// with sof/eol tags and buffers the words behind a valid/ready FIFO.
module ad_line_packer
    import ad_pkg::*;
#(
    parameter int unsigned DW           = AD_DW,
    parameter int unsigned SKIP_SAMPLES = 16,
    parameter int unsigned LINE_SAMPLES = 512,
    parameter int unsigned MAX_LINES    = 256,
    parameter int unsigned FIFO_DEPTH   = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   ad_ch1_i,
    input  logic [DW-1:0]   ad_ch2_i,
    input  logic            sample_valid_i,
    input  logic            hs_i,
    input  logic            vs_i,
    output logic [2*DW-1:0] m_data_o,
    output logic            m_sof_o,
    output logic            m_eol_o,
    output logic            m_valid_o,
    input  logic            m_ready_i,
    output logic [15:0]     line_cnt_o,
    output logic [15:0]     frame_cnt_o,
    output logic            overflow_o,
    output logic            short_line_o
);
    localparam int unsigned CW = $clog2(((SKIP_SAMPLES > LINE_SAMPLES) ? SKIP_SAMPLES : LINE_SAMPLES) + 1);
    localparam int unsigned WW = 2 * DW + 2;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          hs_d;
    logic          vs_d;
    logic          sof_armed;
    logic          push_valid;
    logic [WW-1:0] push_word;
    logic [WW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          hs_fall;
    logic          vs_fall;
    logic          in_line;
    logic          line_done;

    always_comb begin
        hs_fall   = hs_d && !hs_i;
        vs_fall   = vs_d && !vs_i;
        in_line   = (state == ST_SKIP) || (state == ST_CAPTURE);
        line_done = (state == ST_CAPTURE) && sample_valid_i && ((32'(cnt) + 1) == LINE_SAMPLES);
    end

    // Sample handling first; sync edges below override the state and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            hs_d         <= 1'b1;
            vs_d         <= 1'b1;
            sof_armed    <= 1'b0;
            push_valid   <= 1'b0;
            push_word    <= '0;
            line_cnt_o   <= '0;
            frame_cnt_o  <= '0;
            overflow_o   <= 1'b0;
            short_line_o <= 1'b0;
        end else begin
            hs_d       <= hs_i;
            vs_d       <= vs_i;
            push_valid <= 1'b0;
            if (push_valid && fifo_full && !m_ready_i) overflow_o <= 1'b1;

            case (state)
                ST_SKIP: begin
                    if (sample_valid_i) begin
                        if ((32'(cnt) + 1) == SKIP_SAMPLES) begin
                            state <= ST_CAPTURE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid_i) begin
                        push_valid <= 1'b1;
                        push_word  <= {sof_armed, line_done, ad_ch1_i, ad_ch2_i};
                        sof_armed  <= 1'b0;
                        if (line_done) begin
                            state <= ST_WAIT_LINE;
                            cnt   <= '0;
                            if (32'(line_cnt_o) < MAX_LINES) line_cnt_o <= line_cnt_o + 16'd1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase

            if (vs_fall) begin
                state       <= ST_WAIT_LINE;
                cnt         <= '0;
                line_cnt_o  <= '0;
                frame_cnt_o <= frame_cnt_o + 16'd1;
                sof_armed   <= 1'b1;
                if (in_line && !line_done) short_line_o <= 1'b1;
            end else if (hs_fall && (state != ST_IDLE)) begin
                if (in_line && !line_done) short_line_o <= 1'b1;
                cnt <= '0;
                if ((32'(line_cnt_o) + 32'(line_done)) < MAX_LINES)
                    state <= (SKIP_SAMPLES == 0) ? ST_CAPTURE : ST_SKIP;
                else
                    state <= ST_WAIT_LINE;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (push_valid),
        .din   (push_word),
        .rd_en (m_ready_i),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_valid_o                     = !fifo_empty;
    assign {m_sof_o, m_eol_o, m_data_o}  = fifo_dout;

endmodule

// File: tb/tb_ad_line_packer.sv
// Randomised bench for ad_line_packer against a line-level reference model and a FIFO scoreboard.
module tb_ad_line_packer;
    import ad_pkg::*;

    localparam int unsigned DW    = 12;
    localparam int unsigned SKIP  = 4;
    localparam int unsigned LINE  = 8;
    localparam int unsigned MAXL  = 4;
    localparam int unsigned DEPTH = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [DW-1:0]   ch1 = '0;
    logic [DW-1:0]   ch2 = '0;
    logic            sample_valid = 1'b0;
    logic            hs = 1'b1;
    logic            vs = 1'b1;
    logic            m_ready = 1'b0;
    logic [2*DW-1:0] m_data;
    logic            m_sof;
    logic            m_eol;
    logic            m_valid;
    logic [15:0]     line_cnt;
    logic [15:0]     frame_cnt;
    logic            overflow;
    logic            short_line;

    ad_line_packer #(
        .DW(DW), .SKIP_SAMPLES(SKIP), .LINE_SAMPLES(LINE), .MAX_LINES(MAXL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .ad_ch1_i(ch1), .ad_ch2_i(ch2),
        .sample_valid_i(sample_valid), .hs_i(hs), .vs_i(vs),
        .m_data_o(m_data), .m_sof_o(m_sof), .m_eol_o(m_eol), .m_valid_o(m_valid),
        .m_ready_i(m_ready), .line_cnt_o(line_cnt), .frame_cnt_o(frame_cnt),
        .overflow_o(overflow), .short_line_o(short_line)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: frame/line bookkeeping in sample counts, plus an expected-word queue.
    bit       frame_on, line_open, sof_pend, short_exp, ovf_exp;
    int       lines_done, k, frames, nxfer, n_sof, rdy_mode;
    ad_word_t exp_q[$];
    bit       pend, nxt_pend;
    ad_word_t pend_w, nxt_w;

    function automatic void model_reset();
        frame_on = 0; line_open = 0; sof_pend = 0; short_exp = 0; ovf_exp = 0;
        lines_done = 0; k = 0; frames = 0;
        exp_q.delete(); pend = 0; nxt_pend = 0;
    endfunction

    function automatic void model_vs();
        if (line_open) short_exp = 1;
        frame_on = 1; lines_done = 0; frames++; sof_pend = 1; line_open = 0;
    endfunction

    function automatic void model_hs();
        if (!frame_on) return;
        if (line_open) short_exp = 1;
        line_open = (lines_done < int'(MAXL));
        k = 0;
    endfunction

    function automatic void model_sample();
        if (!line_open) return;
        k++;
        if (k > int'(SKIP)) begin
            nxt_w.sof = sof_pend;
            nxt_w.eol = (k == int'(SKIP + LINE));
            nxt_w.ch1 = ch1;
            nxt_w.ch2 = ch2;
            nxt_pend  = 1;
            sof_pend  = 0;
            if (k == int'(SKIP + LINE)) begin
                line_open = 0;
                if (lines_done < int'(MAXL)) lines_done++;
            end
        end
    endfunction

    // One clock: decide ready, score any transfer, land last cycle's push, advance to the next negedge.
    task automatic tick();
        bit pop;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            default: m_ready = ($urandom_range(0, 1) == 1);
        endcase
        if (!reset) begin
            chk("valid", 64'(m_valid), 64'(exp_q.size() != 0));
            pop = m_valid && m_ready;
            if (pop && exp_q.size() != 0) begin
                chk("word", 64'({m_sof, m_eol, m_data}), 64'(exp_q.pop_front()));
                nxfer++;
                if (m_sof) n_sof++;
            end
            if (pend) begin
                if (exp_q.size() < int'(DEPTH)) exp_q.push_back(pend_w);
                else ovf_exp = 1;
            end
            pend = nxt_pend; pend_w = nxt_w; nxt_pend = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic vs_pulse(input int len);
        sample_valid = 1'b0; vs = 1'b0; model_vs();
        repeat (len) tick();
        vs = 1'b1; tick();
    endtask

    task automatic hs_pulse(input int len);
        sample_valid = 1'b0; hs = 1'b0; model_hs();
        repeat (len) tick();
        hs = 1'b1; tick();
    endtask

    task automatic samples(input int n, input int base, input int pv);
        int sent = 0;
        while (sent < n) begin
            if (int'($urandom_range(1, 100)) <= pv) begin
                sample_valid = 1'b1;
                ch1 = DW'(base + sent);
                ch2 = DW'($urandom);
                model_sample();
                sent++;
            end else begin
                sample_valid = 1'b0;
            end
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        rdy_mode = 0;
        while ((exp_q.size() != 0 || pend || m_valid) && g < 200) begin
            tick();
            g++;
        end
        chk("drain_bound", 64'(g < 200), 64'(1));
        idle(3);
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_valid"}, 64'(m_valid), 64'(0));
        chk({t, "_data"}, 64'(m_data), 64'(0));
        chk({t, "_sof"}, 64'(m_sof), 64'(0));
        chk({t, "_eol"}, 64'(m_eol), 64'(0));
        chk({t, "_line_cnt"}, 64'(line_cnt), 64'(0));
        chk({t, "_frame_cnt"}, 64'(frame_cnt), 64'(0));
        chk({t, "_overflow"}, 64'(overflow), 64'(0));
        chk({t, "_short"}, 64'(short_line), 64'(0));
    endtask

    task automatic chk_status(input string t);
        chk({t, "_line_cnt"}, 64'(line_cnt), 64'(lines_done));
        chk({t, "_frame_cnt"}, 64'(frame_cnt), 64'(16'(frames)));
        chk({t, "_overflow"}, 64'(overflow), 64'(ovf_exp));
        chk({t, "_short"}, 64'(short_line), 64'(short_exp));
    endtask

    task automatic do_reset();
        sample_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int x0, s0;
        nxfer = 0; n_sof = 0; rdy_mode = 0;
        model_reset();
        tick();
        do_reset();
        chk_reset("reset");

        // Basic frame: three full lines of 20 samples.
        x0 = nxfer; s0 = n_sof;
        vs_pulse(35);
        repeat (3) begin hs_pulse(35); samples(20, 'h0EF, 100); end
        drain();
        chk("basic_words", 64'(nxfer - x0), 64'(24));
        chk("basic_sof", 64'(n_sof - s0), 64'(1));
        chk("basic_lines", 64'(line_cnt), 64'(3));
        chk("basic_frames", 64'(frame_cnt), 64'(1));
        chk_status("basic");

        // Line limit: six lines, only four captured.
        x0 = nxfer;
        vs_pulse(4);
        repeat (6) begin hs_pulse(3); samples(12 + int'($urandom_range(0, 3)), int'($urandom_range(0, 4000)), 100); end
        drain();
        chk("limit_words", 64'(nxfer - x0), 64'(32));
        chk("limit_lines", 64'(line_cnt), 64'(4));
        chk_status("limit");

        // Backpressure: two lines fill the FIFO, the third overflows.
        x0 = nxfer;
        vs_pulse(3);
        rdy_mode = 1;
        repeat (2) begin hs_pulse(2); samples(12, int'($urandom_range(0, 4000)), 100); end
        idle(4);
        chk("bp_held", 64'(nxfer - x0), 64'(0));
        chk("bp_no_ovf_yet", 64'(overflow), 64'(0));
        hs_pulse(2); samples(12, 'h300, 100);
        idle(4);
        chk("bp_overflow", 64'(overflow), 64'(1));
        drain();
        chk("bp_words", 64'(nxfer - x0), 64'(16));
        chk_status("bp");

        // Short line followed by a full line.
        x0 = nxfer;
        vs_pulse(2);
        chk("short_before", 64'(short_line), 64'(0));
        hs_pulse(2); samples(6, 'h100, 100);
        hs_pulse(2); samples(12, 'h200, 100);
        drain();
        chk("short_flag", 64'(short_line), 64'(1));
        chk("short_lines", 64'(line_cnt), 64'(1));
        chk("short_words", 64'(nxfer - x0), 64'(10));
        chk_status("short");

        // vs edge during capture truncates and starts a new frame.
        hs_pulse(2); samples(7, 'h400, 100);
        s0 = n_sof;
        vs_pulse(2);
        idle(2);
        chk("vsmid_lines", 64'(line_cnt), 64'(0));
        chk_status("vsmid_a");
        hs_pulse(2); samples(12, 'h500, 100);
        drain();
        chk("vsmid_sof", 64'(n_sof - s0), 64'(1));
        chk_status("vsmid_b");

        // Reset in the middle of a captured line; hs ignored until vs.
        hs_pulse(2); samples(8, 'h600, 100);
        do_reset();
        chk_reset("midreset");
        x0 = nxfer;
        hs_pulse(2); samples(14, 'h700, 100);
        idle(4);
        chk("midreset_ignored", 64'(nxfer - x0), 64'(0));
        chk_status("midreset");

        // Random frames with random gaps, line lengths and consumer stalls.
        for (int f = 0; f < 8; f++) begin
            rdy_mode = 2;
            vs_pulse(int'($urandom_range(1, 4)));
            for (int l = 0; l < int'($urandom_range(1, 6)); l++) begin
                hs_pulse(int'($urandom_range(1, 3)));
                samples(int'($urandom_range(0, 16)), int'($urandom_range(0, 4095)), 70);
                idle(int'($urandom_range(0, 3)));
            end
            drain();
            chk_status("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
